stream_demux1to2: RTL and testbench

Packet-aware 1:2 stream demultiplexer with valid/ready handshakes and one registered slot per output. It routes whole packets from a single upstream stream to output y0 or y1, and sits directly downstream of the stream source. The combinational `demux1to2` routing is extended here with flow control, per-packet select locking and per-output packet counters.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/demux_out_slot.sv | 61 ++++++
 rtl/stream_demux1to2.sv | 104 ++++++++++
 tb/tb_stream_demux1to2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
// Shared types and default widths for the packet-aware 1:2 stream demux.
//   state_t    : routing FSM state (IDLE, ROUTE0, ROUTE1)
//   DATA_W_DEF : default payload width
//   CNT_W_DEF  : default per-output packet counter width
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot
// One-entry registered output slot with a packet counter.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture load_data/load_last this cycle
//   load_data/_last   : beat to capture
//   ready             : downstream ready
//   valid, data, last : registered output beat
//   cnt               : packets (beats with last=1) loaded into this slot
//   avail             : slot can take a beat this cycle (empty or draining)
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [CNT_W-1:0]  cnt,
  output logic              avail
);

  logic drain;

  assign drain = valid & ready;
  // A draining slot frees up on the same edge, so it may accept a new beat.
  assign avail = ~valid | ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: data/last are reset too, because the outputs must read 0 after
      // reset; a pure datapath register would normally be left unreset.
      data  <= '0;
      last  <= 1'b0;
      cnt   <= '0;
    end else begin
      // Load has priority over drain: a simultaneous load keeps the slot full.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        last  <= load_last;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (load && load_last) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_demux1to2.sv
// stream_demux1to2
// Routes whole packets from one valid/ready stream to output y0 or y1.
// The destination is taken from in_sel on the first beat and locked until
// the beat carrying in_last has been accepted.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : upstream handshake
//   in_data/in_last/in_sel      : upstream beat, last flag, destination
//   yx_valid/yx_ready           : downstream handshake for output x
//   yx_data/yx_last             : registered beat on output x
//   pkt_cntx                    : packets routed to output x (wrapping)
module stream_demux1to2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              y0_valid,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y0_data,
  output logic              y0_last,
  output logic              y1_valid,
  input  logic              y1_ready,
  output logic [DATA_W-1:0] y1_data,
  output logic              y1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  state_t state, state_nxt;
  logic   sel;
  logic   accept;
  logic   avail0, avail1;

  // Effective select: live in_sel at a packet start, locked mid-packet.
  assign sel = (state == IDLE) ? in_sel : (state == ROUTE1);

  // Head-of-line blocking is intentional: only the selected slot matters.
  assign in_ready = sel ? avail1 : avail0;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_last) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        state_nxt = in_sel ? ROUTE1 : ROUTE0;
      end
    end
  end

  demux_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & ~sel),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (y0_ready),
    .valid     (y0_valid),
    .data      (y0_data),
    .last      (y0_last),
    .cnt       (pkt_cnt0),
    .avail     (avail0)
  );

  demux_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & sel),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (y1_ready),
    .valid     (y1_valid),
    .data      (y1_data),
    .last      (y1_last),
    .cnt       (pkt_cnt1),
    .avail     (avail1)
  );

endmodule

// File: tb/tb_stream_demux1to2.sv
// tb_stream_demux1to2
// Drives one stimulus stream into two instances (CNT_W=8 and CNT_W=2) and
// checks both against a queue-based packet model every cycle, plus directed
// literal expectations for each scenario.
module tb_stream_demux1to2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int CNT_WS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_sel = 1'b0;
  logic              y0_ready = 1'b1;
  logic              y1_ready = 1'b1;

  logic              in_ready, y0_valid, y0_last, y1_valid, y1_last;
  logic [DATA_W-1:0] y0_data, y1_data;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  logic              w_in_ready, w_y0_valid, w_y0_last, w_y1_valid, w_y1_last;
  logic [DATA_W-1:0] w_y0_data, w_y1_data;
  logic [CNT_WS-1:0] w_pkt_cnt0, w_pkt_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_last(y0_last),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_last(y1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  stream_demux1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_WS)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .y0_valid(w_y0_valid), .y0_ready(y0_ready), .y0_data(w_y0_data), .y0_last(w_y0_last),
    .y1_valid(w_y1_valid), .y1_ready(y1_ready), .y1_data(w_y1_data), .y1_last(w_y1_last),
    .pkt_cnt0(w_pkt_cnt0), .pkt_cnt1(w_pkt_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-output queues of {last,data} beats that have been accepted but not
  // yet taken downstream; the head is what the output must present.
  logic [DATA_W:0] q0[$];
  logic [DATA_W:0] q1[$];
  bit              locked;
  bit              lock_sel;
  int unsigned     c0, c1;

  always @(negedge clk) begin
    bit dest, exp_rdy, pop0, pop1;
    if (rst) begin
      q0.delete(); q1.delete();
      locked = 0; c0 = 0; c1 = 0;
      check("rst_y0_valid", {y0_valid, w_y0_valid}, 2'b00);
      check("rst_y1_valid", {y1_valid, w_y1_valid}, 2'b00);
      check("rst_y0_data",  {y0_data, w_y0_data, y0_last, w_y0_last}, '0);
      check("rst_y1_data",  {y1_data, w_y1_data, y1_last, w_y1_last}, '0);
      check("rst_cnt",      {pkt_cnt0, pkt_cnt1, w_pkt_cnt0, w_pkt_cnt1}, '0);
      check("rst_in_ready", {in_ready, w_in_ready}, 2'b11);
    end else begin
      check("y0_valid", {y0_valid, w_y0_valid}, {2{q0.size() != 0}});
      check("y1_valid", {y1_valid, w_y1_valid}, {2{q1.size() != 0}});
      if (q0.size() != 0) begin
        check("y0_beat", {y0_last, y0_data}, q0[0]);
        check("w_y0_beat", {w_y0_last, w_y0_data}, q0[0]);
      end
      if (q1.size() != 0) begin
        check("y1_beat", {y1_last, y1_data}, q1[0]);
        check("w_y1_beat", {w_y1_last, w_y1_data}, q1[0]);
      end
      check("pkt_cnt0", pkt_cnt0, c0 % 256);
      check("pkt_cnt1", pkt_cnt1, c1 % 256);
      check("w_pkt_cnt0", w_pkt_cnt0, c0 % 4);
      check("w_pkt_cnt1", w_pkt_cnt1, c1 % 4);

      dest    = locked ? lock_sel : in_sel;
      exp_rdy = dest ? (q1.size() == 0 || y1_ready) : (q0.size() == 0 || y0_ready);
      check("in_ready", {in_ready, w_in_ready}, {2{exp_rdy}});

      // Advance the model across the coming rising edge.
      pop0 = (q0.size() != 0) && y0_ready;
      pop1 = (q1.size() != 0) && y1_ready;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (dest) q1.push_back({in_last, in_data});
        else      q0.push_back({in_last, in_data});
        if (in_last) begin
          if (dest) c1++; else c0++;
          locked = 0;
        end else if (!locked) begin
          locked   = 1;
          lock_sel = in_sel;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one beat and hold it until accepted; returns cycles waited.
  task automatic beat(input logic s, input logic [DATA_W-1:0] d, input logic l,
                      output int waits);
    logic r;
    in_valid = 1'b1; in_sel = s; in_data = d; in_last = l;
    waits = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #2;
      if (r) break;
      waits++;
      if (waits > 50) begin
        check("beat_timeout", 32'(waits), 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    int w;
    int exp_w[5];
    exp_w = '{1, 2, 3, 0, 1};

    // Reset, then single beat to y0.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t1_in_ready_after_rst", in_ready, 1);
    check("t1_y0_valid_after_rst", y0_valid, 0);
    @(posedge clk); #2;
    beat(1'b0, 8'hA5, 1'b1, w);
    @(negedge clk);
    check("t1_y0_valid", y0_valid, 1);
    check("t1_y0_data", y0_data, 8'hA5);
    check("t1_pkt_cnt0", pkt_cnt0, 1);
    check("t1_y1_valid", y1_valid, 0);

    // Select lock: in_sel ignored after the first beat; full throughput.
    @(posedge clk); #2;
    beat(1'b1, 8'h11, 1'b0, w);
    check("t2_wait0", 32'(w), 0);
    beat(1'b0, 8'h22, 1'b0, w);
    check("t2_wait1", 32'(w), 0);
    @(negedge clk);
    check("t2_y1_data_b1", {y1_valid, y1_data}, {1'b1, 8'h22});
    check("t2_y0_idle_b1", y0_valid, 0);
    @(posedge clk); #2;
    beat(1'b0, 8'h33, 1'b1, w);
    @(negedge clk);
    check("t2_y1_data_b2", {y1_valid, y1_last, y1_data}, {2'b11, 8'h33});
    check("t2_y0_idle_b2", y0_valid, 0);
    check("t2_pkt_cnt1", pkt_cnt1, 1);

    // Backpressure on y0, with y1 free (head-of-line blocking).
    @(posedge clk); #2 y0_ready = 1'b0;
    beat(1'b0, 8'h44, 1'b0, w);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h55; in_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t3_in_ready_blocked", in_ready, 0);
      check("t3_y0_held", {y0_valid, y0_data}, {1'b1, 8'h44});
    end
    @(posedge clk); #2 y0_ready = 1'b1;
    beat(1'b1, 8'h55, 1'b1, w);
    check("t3_wait_after_release", 32'(w), 0);
    @(negedge clk);
    check("t3_y0_second", {y0_valid, y0_last, y0_data}, {2'b11, 8'h55});
    check("t3_y1_untouched", y1_valid, 0);
    check("t3_pkt_cnt0", pkt_cnt0, 2);

    // Independent drain: y1 stuck full, y0 packet still flows.
    @(posedge clk); #2 y1_ready = 1'b0;
    beat(1'b1, 8'h66, 1'b1, w);
    beat(1'b0, 8'h77, 1'b1, w);
    check("t4_wait", 32'(w), 0);
    @(negedge clk);
    check("t4_both_valid", {y0_valid, y1_valid}, 2'b11);
    check("t4_data", {y0_data, y1_data}, {8'h77, 8'h66});
    @(posedge clk); #2 y1_ready = 1'b1;
    @(posedge clk); #2;

    // Reset mid-packet to y1.
    beat(1'b1, 8'hA1, 1'b0, w);
    beat(1'b1, 8'hA2, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    check("t5_outputs_cleared", {y0_valid, y1_valid, y1_data, pkt_cnt0, pkt_cnt1}, '0);
    @(posedge clk); #2 rst = 1'b0;
    beat(1'b0, 8'hB1, 1'b1, w);
    @(negedge clk);
    check("t5_restart_y0", {y0_valid, y0_data}, {1'b1, 8'hB1});
    check("t5_y1_idle", y1_valid, 0);
    check("t5_pkt_cnt0", pkt_cnt0, 1);

    // Counter wrap on the CNT_W=2 instance.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 8'(8'hC0 + i), 1'b1, w);
      @(negedge clk);
      check("t6_w_pkt_cnt0", w_pkt_cnt0, exp_w[i]);
      check("t6_pkt_cnt0", pkt_cnt0, i + 1);
      @(posedge clk); #2;
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
